// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time program loader. Consumes a little-endian byte stream
//   { word count N, N instruction words, 32-bit checksum }, writes each
//   assembled word to instruction memory and releases the core from reset
//   only when the checksum matches the sum of the loaded words.
//
// Ports
//   clk, rst_n   system clock, async active-low reset
//   byte_valid   stream byte present
//   byte_data    stream byte
//   byte_ready   loader accepting bytes (HDR/DATA/CSUM)
//   reload       start a new load; only honoured in DONE/ERR
//   imem_we      one-cycle write strobe (registered)
//   imem_addr    word-aligned byte address of the write (registered, held)
//   imem_wdata   instruction word (registered, held)
//   cpu_rst_n    core reset, released only after a good load
//   load_done    load finished with matching checksum
//   load_err     count out of range or checksum mismatch
module imem_loader #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic        reload,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst_n,
  output logic        load_done,
  output logic        load_err
);

  // Index must reach DEPTH itself, since N == DEPTH is a legal count.
  localparam int IW = $clog2(DEPTH + 1);

  localparam logic [2:0] S_HDR  = 3'd0;
  localparam logic [2:0] S_DATA = 3'd1;
  localparam logic [2:0] S_CSUM = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]    state;
  logic [1:0]    lane;     // byte position within the current 32-bit field
  logic [23:0]   sh;       // lower three bytes of the field being collected
  logic [31:0]   cnt;      // header word count
  logic [31:0]   sum;      // running mod-2^32 sum of written words
  logic [IW-1:0] idx;      // words written so far

  logic          take;
  logic          last;
  logic [31:0]   word;
  logic [31:0]   idx_nx;
  logic [31:0]   wr_addr;

  assign byte_ready = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
  assign take       = byte_valid && byte_ready;
  assign last       = take && (lane == 2'd3);
  // First byte lands in [7:0]; the 4th byte is still on the bus.
  assign word       = {byte_data, sh};
  assign idx_nx     = 32'(idx) + 32'd1;
  assign wr_addr    = BASE_ADDR + (32'(idx) << 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_HDR;
      lane       <= 2'd0;
      sh         <= '0;
      cnt        <= '0;
      sum        <= '0;
      idx        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      cpu_rst_n  <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (take) begin
        sh   <= {byte_data, sh[23:8]};
        lane <= lane + 2'd1;   // wraps 3 -> 0 on the 4th byte
      end
      case (state)
        S_HDR: if (last) begin
          cnt <= word;
          idx <= '0;
          sum <= '0;
          if (word > 32'(DEPTH)) begin
            state    <= S_ERR;
            load_err <= 1'b1;
          end else if (word == 32'd0) begin
            state <= S_CSUM;
          end else begin
            state <= S_DATA;
          end
        end
        S_DATA: if (last) begin
          imem_we    <= 1'b1;
          imem_addr  <= wr_addr;
          imem_wdata <= word;
          sum        <= sum + word;
          idx        <= idx + 1'b1;
          if (idx_nx == cnt) state <= S_CSUM;
        end
        S_CSUM: if (last) begin
          if (word == sum) begin
            state     <= S_DONE;
            load_done <= 1'b1;
            cpu_rst_n <= 1'b1;
          end else begin
            state    <= S_ERR;
            load_err <= 1'b1;
          end
        end
        S_DONE, S_ERR: if (reload) begin
          // Flags and core reset drop together with the state change.
          state     <= S_HDR;
          lane      <= 2'd0;
          load_done <= 1'b0;
          load_err  <= 1'b0;
          cpu_rst_n <= 1'b0;
        end
        default: state <= S_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: bytes are driven on the falling edge and
// outputs are sampled on the falling edge after the accepting rising edge.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        reload;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst_n;
  logic        load_done;
  logic        load_err;

  imem_loader #(.DEPTH(256), .BASE_ADDR(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  logic [7:0]  bq[$];
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [15:0] pat = 16'b1011_0010_0110_1001;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Write log, sampled mid-cycle.
  always @(negedge clk) if (imem_we) begin
    wa.push_back(imem_addr);
    wd.push_back(imem_wdata);
  end

  task automatic q32(input logic [31:0] w);
    bq.push_back(w[7:0]);
    bq.push_back(w[15:8]);
    bq.push_back(w[23:16]);
    bq.push_back(w[31:24]);
  endtask

  // Drive queued bytes; thr inserts idle cycles from a fixed pattern.
  task automatic send(input bit thr);
    for (int i = 0; i < bq.size(); i++) begin
      if (thr && pat[i % 16]) begin
        byte_valid = 1'b0;
        byte_data  = 8'hEE;
        @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_data  = bq[i];
      @(negedge clk);
    end
    byte_valid = 1'b0;
    byte_data  = 8'hEE;
    bq.delete();
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic chk_wr(input int i, input logic [31:0] a, input logic [31:0] d);
    if (i < wa.size()) begin
      chk("wr_addr", wa[i], a);
      chk("wr_data", wd[i], d);
    end else begin
      chk("wr_missing", 32'(wa.size()), 32'(i + 1));
    end
  endtask

  task automatic chk_flags(input string tag, input logic done, input logic err,
                           input logic crst, input logic rdy);
    chk({tag, "_done"}, 32'(load_done), 32'(done));
    chk({tag, "_err"},  32'(load_err),  32'(err));
    chk({tag, "_cpu"},  32'(cpu_rst_n), 32'(crst));
    chk({tag, "_rdy"},  32'(byte_ready), 32'(rdy));
  endtask

  task automatic nominal(input bit thr);
    wa.delete(); wd.delete();
    q32(32'd2); q32(32'h0050_0093); q32(32'h00A0_0113); q32(32'h00F0_01A6);
    send(thr);
    chk("nom_nwr", 32'(wa.size()), 32'd2);
    chk_wr(0, 32'h0, 32'h0050_0093);
    chk_wr(1, 32'h4, 32'h00A0_0113);
    chk_flags("nom", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("hold_addr", imem_addr, 32'h4);
    chk("hold_data", imem_wdata, 32'h00A0_0113);
  endtask

  initial begin
    logic [31:0] s;
    rst_n = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; reload = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal back-to-back load
    nominal(1'b0);

    // Reload, then a single-word load
    pulse_reload();
    chk_flags("rld", 1'b0, 1'b0, 1'b0, 1'b1);
    wa.delete(); wd.delete();
    q32(32'd1); q32(32'h0000_0537); q32(32'h0000_0537);
    send(1'b0);
    chk("rld_nwr", 32'(wa.size()), 32'd1);
    chk_wr(0, 32'h0, 32'h0000_0537);
    chk_flags("rld_end", 1'b1, 1'b0, 1'b1, 1'b0);

    // Checksum mismatch
    pulse_reload();
    wa.delete(); wd.delete();
    q32(32'd2); q32(32'h0050_0093); q32(32'h00A0_0113); q32(32'h00F0_01A7);
    send(1'b0);
    chk("bad_nwr", 32'(wa.size()), 32'd2);
    chk_wr(0, 32'h0, 32'h0050_0093);
    chk_wr(1, 32'h4, 32'h00A0_0113);
    chk_flags("bad", 1'b0, 1'b1, 1'b0, 1'b0);

    // Reload with a simultaneous byte: reload wins, byte dropped
    reload = 1'b1; byte_valid = 1'b1; byte_data = 8'h01;
    @(negedge clk);
    reload = 1'b0; byte_valid = 1'b0;
    chk_flags("rld_byte", 1'b0, 1'b0, 1'b0, 1'b1);

    // Zero count (would misparse if the dropped 0x01 had been taken)
    wa.delete(); wd.delete();
    q32(32'd0); q32(32'd0);
    send(1'b0);
    chk("zero_nwr", 32'(wa.size()), 32'd0);
    chk_flags("zero", 1'b1, 1'b0, 1'b1, 1'b0);

    // Oversize count 257
    pulse_reload();
    wa.delete(); wd.delete();
    bq.push_back(8'h01); bq.push_back(8'h01); bq.push_back(8'h00);
    send(1'b0);
    chk("ovr_pre_err", 32'(load_err), 32'd0);
    bq.push_back(8'h00);
    send(1'b0);
    chk_flags("ovr", 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("ovr_nwr", 32'(wa.size()), 32'd0);

    // N == DEPTH is legal
    pulse_reload();
    wa.delete(); wd.delete();
    s = 32'd0;
    q32(32'd256);
    for (int i = 0; i < 256; i++) begin
      q32(32'h8000_0001 * 32'(i) + 32'h13);
      s = s + (32'h8000_0001 * 32'(i) + 32'h13);
    end
    q32(s);
    send(1'b0);
    chk("full_nwr", 32'(wa.size()), 32'd256);
    chk_wr(255, 32'h3FC, 32'h8000_0001 * 32'd255 + 32'h13);
    chk_flags("full", 1'b1, 1'b0, 1'b1, 1'b0);

    // Throttled nominal load, then bytes during DONE are ignored
    pulse_reload();
    nominal(1'b1);
    q32(32'h1234_5678); q32(32'h0000_0001);
    send(1'b0);
    chk("extra_nwr", 32'(wa.size()), 32'd2);
    chk_flags("extra", 1'b1, 1'b0, 1'b1, 1'b0);

    // Mid-load reset after one DATA word
    pulse_reload();
    q32(32'd2); q32(32'h0050_0093);
    send(1'b0);
    chk("mid_we_pre", 32'(imem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_we", 32'(imem_we), 32'd0);
    chk("mid_addr", imem_addr, 32'h0);
    chk("mid_wdata", imem_wdata, 32'h0);
    chk_flags("mid", 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    nominal(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
